// File: rtl/instr_mem_pkg.sv
// Shared types and field helpers for the fetch-stage instruction memory.
// Field helpers take the word zero-extended to 64 bits; callers size-cast.
package instr_mem_pkg;

  localparam int PC_BITS_DEF  = 12;
  localparam int OP_BITS_DEF  = 3;
  localparam int REG_BITS_DEF = 3;

  typedef enum logic {
    S_LOAD = 1'b0,
    S_RUN  = 1'b1
  } state_e;

  typedef logic [63:0] word_t;

  function automatic logic [31:0] field(
    input word_t w,
    input int    lsb,
    input int    n
  );
    word_t m;
    m = (word_t'(1) << n) - word_t'(1);
    return 32'((w >> lsb) & m);
  endfunction

  function automatic logic [31:0] get_opcode(
    input word_t w,
    input int    op_bits,
    input int    reg_bits
  );
    return field(w, 2 * reg_bits, op_bits);
  endfunction

  function automatic logic [31:0] get_reg1(
    input word_t w,
    input int    reg_bits
  );
    return field(w, reg_bits, reg_bits);
  endfunction

  function automatic logic [31:0] get_reg2(
    input word_t w,
    input int    reg_bits
  );
    return field(w, 0, reg_bits);
  endfunction

endpackage

// File: rtl/instr_fetch_mem_array.sv
// Simple dual-port RAM: one synchronous write port, one registered read
// port whose output holds while the read enable is low.
module instr_mem_array #(
  parameter int AW = 12,
  parameter int DW = 9
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic          re_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
);

  logic [DW-1:0] mem_q [2**AW];
  logic [DW-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/instr_fetch_mem.sv
// Loadable instruction memory for the fetch stage: LOAD streams a program
// in, RUN serves one-cycle registered fetches split into fields.
module instr_fetch_mem
  import instr_mem_pkg::*;
#(
  parameter  int PC_BITS  = PC_BITS_DEF,
  parameter  int OP_BITS  = OP_BITS_DEF,
  parameter  int REG_BITS = REG_BITS_DEF,
  localparam int INS_BITS = OP_BITS + 2 * REG_BITS
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                load_start,
  input  logic                load_valid,
  input  logic [INS_BITS-1:0] load_data,
  input  logic                load_last,
  output logic                load_ready,
  output logic                running,
  input  logic                fetch_req,
  input  logic [PC_BITS-1:0]  pc,
  input  logic                stall,
  output logic                ins_valid,
  output logic [PC_BITS-1:0]  ins_pc,
  output logic [OP_BITS-1:0]  opcode,
  output logic [REG_BITS-1:0] reg1,
  output logic [REG_BITS-1:0] reg2,
  output logic                oob
);

  state_e state_q, state_d;

  logic [PC_BITS-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PC_BITS:0]    prog_len_q, prog_len_d;
  logic [PC_BITS-1:0]  ins_pc_q, ins_pc_d;
  logic                ins_valid_q, ins_valid_d;
  logic                oob_q, oob_d;
  logic                show_q, show_d;

  logic                accept;
  logic                wr_done;
  logic                in_range;
  logic                rd_en;
  logic [INS_BITS-1:0] rdata;
  logic [INS_BITS-1:0] word;

  assign accept   = (state_q == S_LOAD) && load_valid && !load_start;
  assign wr_done  = load_last || (&wr_ptr_q);
  assign in_range = {1'b0, pc} < prog_len_q;
  assign rd_en    = (state_q == S_RUN) && !load_start
                 && !stall && fetch_req && in_range;

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_LOAD;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_LOAD:  if (accept && wr_done) state_d = S_RUN;
      S_RUN:   if (load_start) state_d = S_LOAD;
      default: state_d = S_LOAD;
    endcase
  end

  always_comb begin
    load_ready = (state_q == S_LOAD);
    running    = (state_q == S_RUN);
  end

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    prog_len_d = prog_len_q;
    if (load_start) begin
      wr_ptr_d = '0;
      if (state_q == S_RUN) prog_len_d = '0;
    end else if (accept) begin
      wr_ptr_d = wr_ptr_q + PC_BITS'(1);
      if (wr_done) prog_len_d = {1'b0, wr_ptr_q} + (PC_BITS+1)'(1);
    end
  end

  // Stall freezes every fetch output, RAM output included via rd_en.
  always_comb begin
    ins_valid_d = ins_valid_q;
    ins_pc_d    = ins_pc_q;
    oob_d       = oob_q;
    show_d      = show_q;
    if (state_q == S_LOAD || load_start) begin
      ins_valid_d = 1'b0;
    end else if (!stall) begin
      ins_valid_d = fetch_req;
      if (fetch_req) begin
        ins_pc_d = pc;
        oob_d    = !in_range;
        show_d   = in_range;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q    <= '0;
      prog_len_q  <= '0;
      ins_pc_q    <= '0;
      ins_valid_q <= 1'b0;
      oob_q       <= 1'b0;
      show_q      <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      prog_len_q  <= prog_len_d;
      ins_pc_q    <= ins_pc_d;
      ins_valid_q <= ins_valid_d;
      oob_q       <= oob_d;
      show_q      <= show_d;
    end
  end

  instr_mem_array #(
    .AW (PC_BITS),
    .DW (INS_BITS)
  ) u_array (
    .clk     (clk),
    .we_i    (accept),
    .waddr_i (wr_ptr_q),
    .wdata_i (load_data),
    .re_i    (rd_en),
    .raddr_i (pc),
    .rdata_o (rdata)
  );

  assign word      = show_q ? rdata : '0;
  assign opcode    = OP_BITS'(get_opcode(word_t'(word), OP_BITS, REG_BITS));
  assign reg1      = REG_BITS'(get_reg1(word_t'(word), REG_BITS));
  assign reg2      = REG_BITS'(get_reg2(word_t'(word), REG_BITS));
  assign ins_valid = ins_valid_q;
  assign ins_pc    = ins_pc_q;
  assign oob       = oob_q;

endmodule

// File: tb/tb_instr_fetch_mem.sv
// Bench for instr_fetch_mem: directed vectors, hand sequences and a
// randomized run against an array-based reference model.
module tb_instr_fetch_mem;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, load_start, load_valid, load_last;
  logic [8:0]  load_data;
  logic        fetch_req, stall;
  logic [11:0] pc;
  logic        load_ready, running, ins_valid, oob;
  logic [11:0] ins_pc;
  logic [2:0]  opcode, reg1, reg2;

  logic        s_reset, s_load_start, s_load_valid, s_load_last;
  logic [8:0]  s_load_data;
  logic        s_fetch_req, s_stall;
  logic [1:0]  s_pc;
  logic        s_load_ready, s_running, s_ins_valid, s_oob;
  logic [1:0]  s_ins_pc;
  logic [2:0]  s_opcode, s_reg1, s_reg2;

  int checks = 0;
  int errors = 0;

  instr_fetch_mem #(.PC_BITS(12), .OP_BITS(3), .REG_BITS(3)) u_dut (
    .clk(clk), .reset(reset), .load_start(load_start),
    .load_valid(load_valid), .load_data(load_data),
    .load_last(load_last), .load_ready(load_ready),
    .running(running), .fetch_req(fetch_req), .pc(pc),
    .stall(stall), .ins_valid(ins_valid), .ins_pc(ins_pc),
    .opcode(opcode), .reg1(reg1), .reg2(reg2), .oob(oob)
  );

  instr_fetch_mem #(.PC_BITS(2), .OP_BITS(3), .REG_BITS(3)) u_small (
    .clk(clk), .reset(s_reset), .load_start(s_load_start),
    .load_valid(s_load_valid), .load_data(s_load_data),
    .load_last(s_load_last), .load_ready(s_load_ready),
    .running(s_running), .fetch_req(s_fetch_req), .pc(s_pc),
    .stall(s_stall), .ins_valid(s_ins_valid), .ins_pc(s_ins_pc),
    .opcode(s_opcode), .reg1(s_reg1), .reg2(s_reg2), .oob(s_oob)
  );

  // Reference model: program as a plain array plus a length
  logic [8:0] m_mem [4096];
  int  m_plen = 0, m_wp = 0;
  bit  m_run = 0;
  bit  m_v = 0, m_oob = 0;
  int  m_pc = 0, m_op = 0, m_r1 = 0, m_r2 = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] dut_bus();
    return 32'({ins_valid, ins_pc, opcode, reg1, reg2,
                oob, running, load_ready});
  endfunction

  function automatic logic [31:0] model_bus();
    return 32'({m_v, 12'(m_pc), 3'(m_op), 3'(m_r1), 3'(m_r2),
                m_oob, m_run, !m_run});
  endfunction

  task automatic model_step();
    int w;
    if (reset) begin
      m_run = 0; m_wp = 0; m_plen = 0; m_v = 0;
      m_pc = 0; m_op = 0; m_r1 = 0; m_r2 = 0; m_oob = 0;
    end else if (!m_run) begin
      m_v = 0;
      if (load_start) m_wp = 0;
      else if (load_valid) begin
        m_mem[m_wp] = load_data;
        m_wp++;
        if (load_last || m_wp == 4096) begin
          m_plen = m_wp; m_run = 1; m_wp = m_wp % 4096;
        end
      end
    end else if (load_start) begin
      m_run = 0; m_wp = 0; m_plen = 0; m_v = 0;
    end else if (!stall) begin
      m_v = fetch_req;
      if (fetch_req) begin
        m_pc  = int'(pc);
        m_oob = (int'(pc) >= m_plen);
        w     = m_oob ? 0 : int'(m_mem[pc]);
        m_op  = w / 64;
        m_r1  = (w / 8) % 8;
        m_r2  = w % 8;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    chk("model", dut_bus(), model_bus());
  endtask

  task automatic load_word(input logic [8:0] d, input logic last);
    load_valid = 1'b1; load_data = d; load_last = last;
    tick();
    load_valid = 1'b0; load_last = 1'b0;
  endtask

  typedef struct {
    int pc; int op; int r1; int r2; int oob;
  } vec_t;

  vec_t tv [5];
  logic [8:0] prog [4];
  logic [8:0] sw [4];

  initial begin
    tv[0] = '{0, 7, 0, 5, 0};
    tv[1] = '{1, 3, 7, 2, 0};
    tv[2] = '{2, 4, 4, 3, 0};
    tv[3] = '{3, 7, 7, 7, 0};
    tv[4] = '{4, 0, 0, 0, 1};
    prog[0] = 9'h1C5; prog[1] = 9'h0FA; prog[2] = 9'h123; prog[3] = 9'h1FF;
    sw[0] = 9'h03C; sw[1] = 9'h1A5; sw[2] = 9'h0E1; sw[3] = 9'h157;

    reset = 1; load_start = 0; load_valid = 0; load_last = 0;
    load_data = 0; fetch_req = 0; stall = 0; pc = 0;
    s_reset = 1; s_load_start = 0; s_load_valid = 0; s_load_last = 0;
    s_load_data = 0; s_fetch_req = 0; s_stall = 0; s_pc = 0;
    tick(); tick();
    chk("reset_state", dut_bus(), 32'd1);
    chk("s_reset_state",
        32'({s_ins_valid, s_oob, s_running, s_load_ready}), 32'd1);
    reset = 0; s_reset = 0;

    for (int i = 0; i < 4; i++) begin
      load_word(prog[i], 1'(i == 3));
      chk("running_after_load", 32'(running), 32'(i == 3));
    end

    for (int i = 0; i < 5; i++) begin
      fetch_req = 1; pc = 12'(tv[i].pc);
      tick();
      chk("tbl_valid", 32'(ins_valid), 32'd1);
      chk("tbl_pc", 32'(ins_pc), tv[i].pc);
      chk("tbl_fields", 32'({opcode, reg1, reg2}),
          32'(tv[i].op * 64 + tv[i].r1 * 8 + tv[i].r2));
      chk("tbl_oob", 32'(oob), tv[i].oob);
    end

    pc = 1; tick();
    chk("stall_pre", 32'({ins_pc, opcode, reg1, reg2}), {12'd1, 9'h0FA});
    stall = 1;
    for (int i = 0; i < 3; i++) begin
      pc = 12'(2 + (i % 2));
      tick();
      chk("stall_hold", 32'({ins_valid, ins_pc, opcode, reg1, reg2, oob}),
          32'({1'b1, 12'd1, 9'h0FA, 1'b0}));
    end
    stall = 0; pc = 3; tick();
    chk("stall_release", 32'({ins_valid, ins_pc, opcode, reg1, reg2}),
        32'({1'b1, 12'd3, 9'h1FF}));
    fetch_req = 0; tick();
    chk("idle_hold", 32'({ins_valid, ins_pc}), 32'({1'b0, 12'd3}));

    fetch_req = 1; pc = 0; load_start = 1; tick();
    chk("reload_start", 32'({ins_valid, load_ready, running}), 32'b010);
    load_start = 0; fetch_req = 0;
    load_word(9'h0AB, 0);
    load_word(9'h155, 1);
    fetch_req = 1; pc = 2; tick();
    chk("reload_oob", 32'({ins_valid, oob, opcode, reg1, reg2}),
        32'({1'b1, 1'b1, 9'h000}));
    pc = 1; tick();
    chk("reload_word1", 32'({oob, opcode, reg1, reg2}), 32'({1'b0, 9'h155}));
    fetch_req = 0;

    for (int i = 0; i < 4; i++) begin
      s_load_valid = 1; s_load_data = sw[i];
      tick();
      chk("s_auto_run", 32'({s_running, s_load_ready}),
          (i == 3) ? 32'b10 : 32'b01);
    end
    s_load_data = 9'h0AA; tick();
    chk("s_fifth_ignored", 32'({s_running, s_load_ready}), 32'b10);
    s_load_valid = 0; s_fetch_req = 1;
    for (int i = 0; i < 4; i++) begin
      s_pc = 2'(i); tick();
      chk("s_fetch", 32'({s_ins_valid, s_oob, s_ins_pc,
                          s_opcode, s_reg1, s_reg2}),
          32'({1'b1, 1'b0, 2'(i), sw[i]}));
    end
    s_fetch_req = 0;

    load_start = 1; tick(); load_start = 0;
    load_word(9'h011, 0);
    load_word(9'h022, 0);
    reset = 1; tick();
    chk("reset_midload", dut_bus(), 32'd1);
    reset = 0;
    load_word(9'h033, 1);
    fetch_req = 1; pc = 0; tick();
    chk("wrptr_restart", 32'({oob, opcode, reg1, reg2}), 32'({1'b0, 9'h033}));
    pc = 1; tick();
    chk("wrptr_len", 32'(oob), 32'd1);
    pc = 0; tick();
    stall = 1; tick();
    reset = 1; tick();
    chk("reset_midrun", dut_bus(), 32'd1);
    reset = 0; stall = 0; fetch_req = 0; tick();

    for (int n = 0; n < 1500; n++) begin
      reset      = ($urandom_range(0, 199) == 0);
      load_start = ($urandom_range(0, 29) == 0);
      load_valid = $urandom_range(0, 1) == 1;
      load_last  = ($urandom_range(0, 7) == 0);
      load_data  = 9'($urandom);
      fetch_req  = ($urandom_range(0, 3) != 0);
      stall      = ($urandom_range(0, 3) == 0);
      pc         = 12'($urandom_range(0, 20));
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
